mmio_uart_responder: RTL and testbench

- Memory-mapped UART transmit peripheral that answers on the VerySimpleCPU RAM port (wrEn / addr_toRAM / data_toRAM / data_fromRAM), alongside blram.
- Decodes a 4-word address window above RAM and buffers CPU-written bytes in a FIFO. It serialises them 8N1 on o_tx.
- Read timing matches blram: data registered one clock after the address; read-before-write on the same address.
- An external mux selects o_ram_data_out when o_hit=1, otherwise blram data.

---
 rtl/mmio_uart_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mmio_uart_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_responder.sv
// mmio_uart_responder: memory-mapped 8N1 UART transmitter that answers on the
// VerySimpleCPU RAM port next to blram. Registers (word offsets from BASE):
//   0 TXDATA, 1 STATUS, 2 CTRL, 3 SENT.
// Read data is registered one clock after the address and shows the value
// held before any write in that same cycle, matching blram timing.
//
// TX FSM
//   state    | meaning
//   ST_IDLE  | line high, waiting for enable and a queued byte
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | eight data bits, LSB first, one bit period each
//   ST_STOP  | stop bit (high); may chain straight into the next ST_START
module mmio_uart_responder #(
  parameter int SIZE         = 14,
  parameter int BASE         = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [SIZE-1:0] i_addr,
  input  logic [31:0]     i_ram_data_in,
  output logic [31:0]     o_ram_data_out,
  output logic            o_hit,
  output logic            o_tx,
  output logic            o_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [SIZE-1:0] BASE_ADDR = SIZE'(BASE);
  localparam logic [BW-1:0]   BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Register-window decode
  logic       sel;
  logic [1:0] offset;
  logic       wr_en;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_empty, fifo_full;
  logic          push, push_ok, pop;
  logic [7:0]    fifo_head;

  // Control / status registers
  logic        enable_q, enable_d;
  logic [31:0] sent_q, sent_d;
  logic        frame_done;

  // Transmitter
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  // Read port
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;

  // Only the low byte / low control bits of the write data carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^i_ram_data_in[31:8];

  assign sel     = (i_addr[SIZE-1:2] == BASE_ADDR[SIZE-1:2]);
  assign offset  = i_addr[1:0];
  assign wr_en   = i_we & sel;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign push       = wr_en && (offset == 2'd0);
  assign push_ok    = push && !fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q];

  // FIFO pointers, occupancy and sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A clear and an overflowing push cannot coincide: they use different offsets.
    if (wr_en && (offset == 2'd2) && i_ram_data_in[1]) begin
      overflow_d = 1'b0;
    end else if (push && fifo_full) begin
      overflow_d = 1'b1;
    end
  end

  // CTRL enable and SENT frame counter; a SENT write beats a same-cycle increment
  always_comb begin
    enable_d = enable_q;
    sent_d   = sent_q;
    if (frame_done) begin
      sent_d = sent_q + 32'd1;
    end
    if (wr_en && (offset == 2'd3)) begin
      sent_d = '0;
    end
    if (wr_en && (offset == 2'd2)) begin
      enable_d = i_ram_data_in[0];
    end
  end

  // TX FSM next state; bit timer is a down-counter reloaded on every bit boundary
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = ST_START;
          baud_d  = BAUD_LOAD;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d = ST_DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          frame_done = 1'b1;
          if (enable_q && !fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
            baud_d  = BAUD_LOAD;
          end else begin
            state_d = ST_IDLE;
            baud_d  = '0;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line and busy are registered from the next state so they move with it.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Register read mux, sampled from pre-write state
  always_comb begin
    rdata_d = '0;
    hit_d   = sel;
    if (sel) begin
      case (offset)
        2'd1:    rdata_d = {16'd0, 8'(count_q), 3'd0, overflow_q, enable_q,
                            busy_q, fifo_full, fifo_empty};
        2'd2:    rdata_d = {31'd0, enable_q};
        2'd3:    rdata_d = sent_q;
        default: rdata_d = '0;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_ram_data_in[7:0];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b1;
      sent_q     <= '0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
      sent_q     <= sent_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
    end
  end

  assign o_ram_data_out = rdata_q;
  assign o_hit          = hit_q;
  assign o_tx           = tx_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Bench for mmio_uart_responder: register reads checked directly, serial
// frames decoded from o_tx and matched against a queue of expected bytes.
module tb_mmio_uart_responder;

  localparam int SIZE = 14;
  localparam int BASE = 1024;
  localparam int DEPTH = 8;
  localparam int CPB = 10;

  localparam logic [SIZE-1:0] A_TX  = SIZE'(BASE);
  localparam logic [SIZE-1:0] A_ST  = SIZE'(BASE + 1);
  localparam logic [SIZE-1:0] A_CT  = SIZE'(BASE + 2);
  localparam logic [SIZE-1:0] A_SN  = SIZE'(BASE + 3);
  localparam logic [SIZE-1:0] A_OUT = SIZE'(50);

  logic            clk = 1'b0;
  logic            rst;
  logic            i_we;
  logic [SIZE-1:0] i_addr;
  logic [31:0]     i_ram_data_in;
  logic [31:0]     o_ram_data_out;
  logic            o_hit;
  logic            o_tx;
  logic            o_busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_uart_responder #(
    .SIZE(SIZE), .BASE(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_we(i_we),
    .i_addr(i_addr),
    .i_ram_data_in(i_ram_data_in),
    .o_ram_data_out(o_ram_data_out),
    .o_hit(o_hit),
    .o_tx(o_tx),
    .o_busy(o_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [SIZE-1:0] a, input logic [31:0] d);
    i_we = 1'b1;
    i_addr = a;
    i_ram_data_in = d;
    tick();
    i_we = 1'b0;
    i_addr = A_OUT;
    i_ram_data_in = '0;
  endtask

  task automatic rd(input logic [SIZE-1:0] a, input logic [31:0] exp, input string tag);
    i_we = 1'b0;
    i_addr = a;
    tick();
    check_val({tag, "_hit"}, {31'd0, o_hit}, {31'd0, (a[SIZE-1:2] == A_TX[SIZE-1:2])});
    check_val(tag, o_ram_data_out, exp);
    i_addr = A_OUT;
  endtask

  task automatic wait_idle(output int n, input int max_cycles);
    n = 0;
    while (o_busy && n < max_cycles) begin
      tick();
      n++;
    end
    check_val("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  // Serial monitor: detect start, sample mid-bit, compare against the scoreboard
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (o_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        mon_byte = '0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2) begin
        check_val("start_bit", {31'd0, o_tx}, 32'd0);
      end else if (mon_cnt > CPB && mon_cnt < 9 * CPB && (mon_cnt % CPB) == CPB / 2) begin
        mon_byte[mon_cnt / CPB - 1] = o_tx;
      end else if (mon_cnt == 9 * CPB + CPB / 2) begin
        check_val("stop_bit", {31'd0, o_tx}, 32'd1);
        check_val("frame_pending", {31'd0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) begin
          check_val("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [7:0] b;

    rst = 1'b1;
    i_we = 1'b0;
    i_addr = A_OUT;
    i_ram_data_in = '0;
    repeat (10) tick();
    check_val("rst_tx", {31'd0, o_tx}, 32'd1);
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_hit", {31'd0, o_hit}, 32'd0);
    rst = 1'b0;

    // Reset state and decode
    rd(A_ST, 32'h0000_0009, "status_rst");
    rd(A_OUT, 32'd0, "rd_outside");
    rd(A_TX, 32'd0, "txdata_rd");
    rd(A_CT, 32'd1, "ctrl_rst");
    wr(A_ST, 32'hFFFF_FFFF);
    rd(A_ST, 32'h0000_0009, "status_ro");

    // Single byte: latency and frame length
    exp_q.push_back(8'h55);
    wr(A_TX, 32'h0000_0055);
    check_val("lat_pre", {31'd0, o_tx}, 32'd1);
    tick();
    check_val("lat_fall", {31'd0, o_tx}, 32'd0);
    check_val("busy_on", {31'd0, o_busy}, 32'd1);
    wait_idle(n, 400);
    check_val("frame_len", n, 100);
    rd(A_SN, 32'd1, "sent_1");
    wr(A_SN, 32'd0);
    rd(A_SN, 32'd0, "sent_clr");

    // Back-to-back frames
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    wr(A_TX, 32'h41);
    wr(A_TX, 32'h42);
    wr(A_TX, 32'h43);
    rd(A_ST, 32'h0000_020C, "status_cnt2");
    wait_idle(n, 1000);
    check_val("b2b_len", n, 298);
    rd(A_SN, 32'd3, "sent_3");

    // Overflow with transmitter disabled
    wr(A_CT, 32'd0);
    rd(A_CT, 32'd0, "ctrl_off");
    for (int i = 0; i < 9; i++) begin
      b = 8'h10 + 8'(i);
      if (i < DEPTH) exp_q.push_back(b);
      wr(A_TX, {24'd0, b});
    end
    rd(A_ST, 32'h0000_0812, "status_ovf");
    wr(A_CT, 32'd3);
    rd(A_ST, 32'h0000_080A, "status_ovf_clr");
    wait_idle(n, 2000);
    check_val("ovf_len", n, 800);
    check_val("ovf_drained", exp_q.size(), 32'd0);
    rd(A_CT, 32'd1, "ctrl_rd");
    rd(A_ST, 32'h0000_0009, "status_after");
    rd(A_SN, 32'd11, "sent_11");

    // Read-before-write on SENT
    wr(A_SN, 32'd0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hA5);
    wr(A_TX, 32'h00);
    wr(A_TX, 32'hFF);
    wr(A_TX, 32'h80);
    wr(A_TX, 32'h01);
    wr(A_TX, 32'hA5);
    wait_idle(n, 1000);
    check_val("five_len", n, 497);
    wr(A_SN, 32'h0000_1234);
    check_val("rbw_hit", {31'd0, o_hit}, 32'd1);
    check_val("rbw_data", o_ram_data_out, 32'd5);
    rd(A_SN, 32'd0, "rbw_after");

    // Reset during data bit 3 with bytes queued
    for (int i = 0; i < 4; i++) begin
      wr(A_TX, 32'hC0 + 32'(i));
    end
    repeat (43) tick();
    check_val("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    tick();
    check_val("rst_mid_tx", {31'd0, o_tx}, 32'd1);
    check_val("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    rd(A_ST, 32'h0000_0009, "status_rst_mid");
    bad = 0;
    repeat (200) begin
      tick();
      if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check_val("no_frames", bad, 32'd0);
    rd(A_SN, 32'd0, "sent_rst");
    check_val("q_final", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
